// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: opcode field geometry and the fetch FIFO entry payload.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 11;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOOP = 5'b00000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic opcode_t op_of(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry skid FIFO of fetched {instr, pc} pairs; flush empties it in one edge.
module fetch_fifo2
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Flush wins over push/pop; stale entry contents are harmless once count is zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word reads, buffers returns and hands them to decode.
// Optional IFETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned    N        = INSTR_W,
    parameter int unsigned    AW       = ADDR_W,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic [N-1:0]    imem_rdata,
    input  logic            redirect,
    input  logic [AW-1:0]   redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [N-1:0]    id_instr,
    output logic [AW-1:0]   id_pc,
    output logic [OP_W-1:0] id_op
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] req_addr_q;
    logic          inflight_q;
    logic          issue_c;
    logic          kill_c;
    logic          push_c;
    logic          pop_c;
    logic [2:0]    credit_c;
    logic [1:0]    count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;

    // Credit counts the slot freed by this cycle's pop so a draining FIFO sustains one fetch per cycle.
    assign pop_c    = id_valid & id_ready;
    assign kill_c   = redirect;
    assign push_c   = inflight_q & ~kill_c;
    assign credit_c = 3'(count) + 3'(inflight_q) - 3'(pop_c);
    assign issue_c  = ~redirect & (credit_c < 3'd2);
    assign pc_d     = redirect ? redirect_pc : (issue_c ? pc_q + AW'(1) : pc_q);

    assign imem_req  = issue_c & reset_n;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue_c;
            req_addr_q <= pc_q;
        end
    end

    assign push_data.instr = INSTR_W'(imem_rdata);
    assign push_data.pc    = ADDR_W'(req_addr_q);

    fetch_fifo2 u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (kill_c),
        .push_i      (push_c),
        .push_data_i (push_data),
        .pop_i       (pop_c),
        .head_o      (head),
        .count_o     (count)
    );

    // Empty FIFO presents a NOOP at pc 0 to decode.
    assign id_valid = (count != 2'd0);
    assign id_instr = id_valid ? N'(head.instr) : '0;
    assign id_pc    = id_valid ? AW'(head.pc) : '0;
    assign id_op    = id_valid ? op_of(head.instr) : OP_NOOP;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(pop_c);
            bubbles_q <= bubbles_q + 32'(id_ready & ~id_valid);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule
